// File: rtl/popcount_pkg.sv
// Shared types and constants for the sequential popcount block.
package popcount_pkg;

  localparam int CHUNK_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ones_count3.sv
// Combinational 3-input ones-counter: {c1,c0} = a + b + c.
module ones_count3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic c1,
  output logic c0
);

  assign c0 = a ^ b ^ c;
  assign c1 = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/popcount_seq_ctrl.sv
// Sequential popcount: one shared ones_count3 walks the word 3 bits per cycle.
// Define POPCNT_EARLY_EXIT_EN to finish as soon as the remaining chunks are all zero.
module popcount_seq_ctrl
  import popcount_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] out_count,
  output logic                       busy
);

  localparam int NCHUNK = (WIDTH + CHUNK_W - 1) / CHUNK_W;
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int SH_W   = CHUNK_W * NCHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t             state_q, state_d;
  logic [SH_W-1:0]    shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic [1:0]         cnt;
  logic [CNT_W-1:0]   acc_sum;
  logic               last_chunk;

  ones_count3 u_ones_count3 (
    .a  (shreg_q[0]),
    .b  (shreg_q[1]),
    .c  (shreg_q[2]),
    .c1 (cnt[1]),
    .c0 (cnt[0])
  );

  assign acc_sum = acc_q + CNT_W'(cnt);

`ifdef POPCNT_EARLY_EXIT_EN
  // Nothing left to count once the bits above the current chunk are all zero.
  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1)) || ((shreg_q >> CHUNK_W) == '0);
`else
  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));
`endif

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_count_d = out_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
          shreg_d = SH_W'(in_data);
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      S_RUN: begin
        acc_d   = acc_sum;
        shreg_d = shreg_q >> CHUNK_W;
        idx_d   = idx_q + IDX_W'(1);
        if (last_chunk) begin
          state_d     = S_DONE;
          out_count_d = acc_sum;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_count = out_count_q;

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Scoreboard bench: drivers push expected {count, due cycle}; monitors pop on each out_valid rise.
module tb_popcount_seq_ctrl;

  typedef struct {
    int count;
    int due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [11:0] in_data;
  logic [3:0]  out_count;

  logic        in_valid3, in_ready3, out_valid3, out_ready3, busy3;
  logic [2:0]  in_data3;
  logic [1:0]  out_count3;

  exp_t q12[$];
  exp_t q3[$];
  logic prev_valid12 = 1'b0;
  logic prev_valid3  = 1'b0;

  popcount_seq_ctrl #(.WIDTH(12)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  popcount_seq_ctrl #(.WIDTH(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .in_data   (in_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_count (out_count3),
    .busy      (busy3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_lat(input logic [11:0] d, input int nchunk);
    int hi;
    int lat;
    hi = 0;
    for (int k = 0; k < nchunk; k++)
      if (((d >> (3 * k)) & 12'h007) != 12'h000) hi = k;
    lat = hi + 1;
`ifndef POPCNT_EARLY_EXIT_EN
    lat = nchunk;
`endif
    return lat;
  endfunction

  // Monitors: compare on the first cycle out_valid is seen high.
  always @(negedge clk) begin
    if (out_valid && !prev_valid12) begin
      if (q12.size() == 0) check("unexpected_out12", 1, 0);
      else begin
        check("count12", 32'(out_count), q12[0].count);
        check("latency12", cyc, q12[0].due);
        void'(q12.pop_front());
      end
    end
    prev_valid12 <= out_valid;
  end

  always @(negedge clk) begin
    if (out_valid3 && !prev_valid3) begin
      if (q3.size() == 0) check("unexpected_out3", 1, 0);
      else begin
        check("count3", 32'(out_count3), q3[0].count);
        check("latency3", cyc, q3[0].due);
        void'(q3.pop_front());
      end
    end
    prev_valid3 <= out_valid3;
  end

  task automatic send(input logic [11:0] d, input bit push, input int cnt);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) check("accept_timeout12", 0, 1);
    else if (push) q12.push_back('{cnt, cyc + 1 + exp_lat(d, 4)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  task automatic send3(input logic [2:0] d, input int cnt);
    @(negedge clk);
    in_valid3 = 1'b1;
    in_data3  = d;
    for (int i = 0; i < 50 && !in_ready3; i++) @(negedge clk);
    if (!in_ready3) check("accept_timeout3", 0, 1);
    else q3.push_back('{cnt, cyc + 2});
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
    in_data3  = ~d;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (q12.size() != 0 || q3.size() != 0 || !in_ready || !in_ready3); i++)
      @(negedge clk);
    check("drain_q12", q12.size(), 0);
    check("drain_q3", q3.size(), 0);
  endtask

  logic [11:0] vec_d [5] = '{12'hFFF, 12'hA5A, 12'h000, 12'h800, 12'h007};
  int          vec_c [5] = '{12, 6, 0, 1, 3};
  int          cnt3  [8] = '{0, 1, 1, 2, 1, 2, 2, 3};

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    in_valid3  = 1'b0;
    in_data3   = '0;
    out_ready3 = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_in_ready3", in_ready3, 1);

    // Back-to-back words with an always-ready consumer.
    for (int i = 0; i < 5; i++) send(vec_d[i], 1'b1, vec_c[i]);
    drain();

    // Consumer stalls: result and handshake must hold.
    out_ready = 1'b0;
    send(12'h0F0, 1'b1, 4);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("stall_seen_valid", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_count", out_count, 4);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    check("release_out_count_kept", out_count, 4);
    check("release_busy", busy, 0);

    // Reset mid-RUN aborts the word without any output.
    send(12'hFFF, 1'b0, 12);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    repeat (8) @(negedge clk);
    send(12'h001, 1'b1, 1);
    drain();

    // WIDTH=3: every pattern through the single-chunk instance.
    for (int p = 0; p < 8; p++) send3(3'(p), cnt3[p]);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule
